// File: rtl/gon_glb_writer.sv
`default_nettype none
// ============================================================================
// Module      : gon_glb_writer
// Description : Receives the serialized packet stream from the global output
//               network bus, packs PACK_NUM consecutive packets into one GLB
//               word and writes the words to consecutive GLB addresses from a
//               programmed base. Started by the top controller per transfer;
//               signals completion with a one-cycle done pulse.
// Ports       : i_clk, i_rst (async, active-low)
//               i_start, i_base_addr, i_word_cnt  -> transfer configuration
//               o_busy, o_done                     -> transfer status
//               i_packet, i_valid, o_ready         -> GON bus input side
//               o_glb_we, o_glb_addr, o_glb_wdata,
//               i_glb_ready                        -> GLB write side
// Revision    : 1.0 - initial release
// ============================================================================
module gon_glb_writer #(
    parameter int DATA_BITWIDTH = 8,
    parameter int PACK_NUM      = 4,
    parameter int ADDR_BITWIDTH = 10,
    parameter int LEN_BITWIDTH  = 10
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [ADDR_BITWIDTH-1:0]          i_base_addr,
    input  logic [LEN_BITWIDTH-1:0]           i_word_cnt,
    output logic                              o_busy,
    output logic                              o_done,
    input  logic [DATA_BITWIDTH-1:0]          i_packet,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic                              o_glb_we,
    output logic [ADDR_BITWIDTH-1:0]          o_glb_addr,
    output logic [PACK_NUM*DATA_BITWIDTH-1:0] o_glb_wdata,
    input  logic                              i_glb_ready
);

    localparam int                c_LANE_BITS = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam logic [c_LANE_BITS-1:0] c_LAST_LANE = c_LANE_BITS'(PACK_NUM - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                                r_state;
    state_t                                w_state_next;

    logic [ADDR_BITWIDTH-1:0]              r_addr;
    logic [LEN_BITWIDTH-1:0]               r_remaining;
    logic [LEN_BITWIDTH-1:0]               r_word_cnt;
    logic [LEN_BITWIDTH-1:0]               r_packed_words;
    logic [c_LANE_BITS-1:0]                r_lane_idx;
    // Only the lower PACK_NUM-1 lanes need storage: the top lane is taken
    // straight from the bus on the packet that completes the word.
    logic [PACK_NUM-2:0][DATA_BITWIDTH-1:0] r_lanes;
    logic [PACK_NUM*DATA_BITWIDTH-1:0]     r_wdata;
    logic                                  r_glb_we;
    logic                                  r_done;

    logic                                  w_start_ok;
    logic                                  w_ready;
    logic                                  w_final_wr;
    logic                                  w_xfer;
    logic                                  w_word_done;
    logic                                  w_wr_hs;
    logic [PACK_NUM*DATA_BITWIDTH-1:0]     w_full_word;

    assign w_wr_hs     = r_glb_we && i_glb_ready;
    assign w_xfer      = i_valid && w_ready;
    assign w_word_done = w_xfer && (r_lane_idx == c_LAST_LANE);
    assign w_full_word = {i_packet, r_lanes};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_ready      = 1'b0;
        w_final_wr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_ok = 1'b1;
                    if (i_word_cnt != '0) begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // A pending write that the GLB refuses this cycle must block
                // the packet that could otherwise overwrite the output word.
                w_ready = (r_packed_words < r_word_cnt) && (!r_glb_we || i_glb_ready);
                if (w_wr_hs && (r_remaining == LEN_BITWIDTH'(1))) begin
                    w_final_wr   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: lane packing, output word register, address/count tracking
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr         <= '0;
            r_remaining    <= '0;
            r_word_cnt     <= '0;
            r_packed_words <= '0;
            r_lane_idx     <= '0;
            r_lanes        <= '0;
            r_wdata        <= '0;
            r_glb_we       <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= (w_start_ok && (i_word_cnt == '0)) || w_final_wr;

            if (w_start_ok) begin
                r_addr         <= i_base_addr;
                r_remaining    <= i_word_cnt;
                r_word_cnt     <= i_word_cnt;
                r_packed_words <= '0;
                r_lane_idx     <= '0;
                r_glb_we       <= 1'b0;
            end else begin
                if (w_xfer) begin
                    // PACK_NUM is a power of two, so the natural wrap of the
                    // index width gives the modulo-PACK_NUM sequence.
                    r_lane_idx <= r_lane_idx + c_LANE_BITS'(1);
                    for (int i = 0; i < PACK_NUM - 1; i++) begin
                        if (r_lane_idx == c_LANE_BITS'(i)) begin
                            r_lanes[i] <= i_packet;
                        end
                    end
                end

                if (w_word_done) begin
                    r_wdata        <= w_full_word;
                    r_packed_words <= r_packed_words + LEN_BITWIDTH'(1);
                end

                if (w_wr_hs) begin
                    r_addr      <= r_addr + ADDR_BITWIDTH'(1);
                    r_remaining <= r_remaining - LEN_BITWIDTH'(1);
                end

                // A word completing in the same cycle as a handshake keeps
                // the request asserted for the freshly loaded word.
                if (w_word_done) begin
                    r_glb_we <= 1'b1;
                end else if (w_wr_hs) begin
                    r_glb_we <= 1'b0;
                end
            end
        end
    end

    assign o_busy      = (r_state == S_RUN);
    assign o_done      = r_done;
    assign o_ready     = w_ready;
    assign o_glb_we    = r_glb_we;
    assign o_glb_addr  = r_addr;
    assign o_glb_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_gon_glb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gon_glb_writer
// Description : Self-checking bench for gon_glb_writer. Directed transfer
//               table plus randomized transfers checked against a queue-based
//               reference of accepted packets and expected GLB words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gon_glb_writer;

    localparam int PN = 4;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [9:0]  i_base_addr;
    logic [9:0]  i_word_cnt;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  i_packet;
    logic        i_valid;
    logic        o_ready;
    logic        o_glb_we;
    logic [9:0]  o_glb_addr;
    logic [31:0] o_glb_wdata;
    logic        i_glb_ready;

    gon_glb_writer #(
        .DATA_BITWIDTH (8),
        .PACK_NUM      (PN),
        .ADDR_BITWIDTH (10),
        .LEN_BITWIDTH  (10)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_word_cnt  (i_word_cnt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .i_packet    (i_packet),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_glb_we    (o_glb_we),
        .o_glb_addr  (o_glb_addr),
        .o_glb_wdata (o_glb_wdata),
        .i_glb_ready (i_glb_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] pkt_src [0:63];

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One complete transfer. Inputs are driven at the falling edge, outputs
    // sampled 1 time unit later. Every write handshake is compared with the
    // word built from the packets the bench saw accepted, in order.
    task automatic run_xfer(input logic [9:0] base, input logic [9:0] cnt,
                            input int vprob, input int rprob, input int stall_n,
                            input bit mid_start,
                            output int n_wr, output int done_it,
                            output logic [9:0] a_first, output logic [31:0] d_first,
                            output logic [9:0] a_last,  output logic [31:0] d_last);
        logic [7:0]  acc[$];
        logic [9:0]  exp_a;
        logic [31:0] exp_d;
        logic [9:0]  prev_addr;
        logic [31:0] prev_data;
        bit          prev_stall;
        bit          prev_final;
        bit          done_seen;
        int          next_idx;
        int          stall_left;
        acc.delete();
        n_wr       = 0;
        done_it    = -1;
        next_idx   = 0;
        stall_left = stall_n;
        prev_stall = 1'b0;
        prev_final = 1'b0;
        done_seen  = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        a_first = '0; d_first = '0; a_last = '0; d_last = '0;

        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = base; i_word_cnt = cnt;
        i_valid = 1'b0; i_glb_ready = 1'b0;

        for (int it = 0; it < 2000 && !done_seen; it++) begin
            @(negedge i_clk);
            i_start     = mid_start && (it == 3);
            i_base_addr = mid_start ? 10'h2AA : base;
            i_word_cnt  = mid_start ? 10'd5   : cnt;
            i_valid     = ($urandom_range(99) < vprob);
            i_packet    = pkt_src[next_idx % 64];
            if (o_glb_we && stall_left > 0) begin
                i_glb_ready = 1'b0;
                stall_left--;
            end else begin
                i_glb_ready = ($urandom_range(99) < rprob);
            end
            #1;
            if (it == 0) check(o_busy == 1'b1, "busy_after_start", 64'(o_busy), 64'h1);
            if (prev_stall)
                check(o_glb_we && o_glb_addr == prev_addr && o_glb_wdata == prev_data,
                      "stall_hold", {o_glb_we, o_glb_addr, o_glb_wdata},
                      {1'b1, prev_addr, prev_data});
            if (o_glb_we && !i_glb_ready)
                check(o_ready == 1'b0, "stall_blocks_input", 64'(o_ready), 64'h0);
            if (acc.size() == int'(cnt) * PN)
                check(o_ready == 1'b0, "no_extra_packet", 64'(o_ready), 64'h0);
            if (prev_final || o_done) begin
                check(prev_final && o_done && !o_busy, "done_pulse",
                      {prev_final, o_done, o_busy}, 64'h6);
                done_seen = 1'b1;
                done_it   = it;
            end

            if (i_valid && o_ready) begin
                acc.push_back(i_packet);
                next_idx++;
            end
            prev_final = 1'b0;
            if (o_glb_we && i_glb_ready) begin
                exp_a = base + 10'(n_wr);
                for (int l = 0; l < PN; l++) exp_d[l*8 +: 8] = acc[n_wr*PN + l];
                check(o_glb_addr == exp_a && o_glb_wdata == exp_d, "write_word",
                      {o_glb_addr, o_glb_wdata}, {exp_a, exp_d});
                if (n_wr == 0) begin a_first = o_glb_addr; d_first = o_glb_wdata; end
                a_last = o_glb_addr; d_last = o_glb_wdata;
                n_wr++;
                prev_final = (n_wr == int'(cnt));
            end
            prev_stall = o_glb_we && !i_glb_ready;
            prev_addr  = o_glb_addr;
            prev_data  = o_glb_wdata;
        end
        if (!done_seen) check(1'b0, "done_timeout", 64'h0, 64'h1);
        i_start = 1'b0; i_valid = 1'b0; i_glb_ready = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  base;
        logic [9:0]  cnt;
        logic [7:0]  pkt0;
        int          vprob;
        int          rprob;
        int          stall_n;
        bit          mid_start;
        bit          pre_reset;
        bit          full_rate;
        logic [9:0]  exp_a_first;
        logic [31:0] exp_d_first;
        logic [9:0]  exp_a_last;
        logic [31:0] exp_d_last;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        int          n_wr;
        int          done_it;
        logic [9:0]  a_first;
        logic [9:0]  a_last;
        logic [31:0] d_first;
        logic [31:0] d_last;
        logic [9:0]  rb;
        logic [9:0]  rc;

        vecs[0] = '{10'h010, 10'd2, 8'h01, 100, 100, 0, 1'b0, 1'b0, 1'b1,
                    10'h010, 32'h04030201, 10'h011, 32'h08070605};
        vecs[1] = '{10'h010, 10'd2, 8'h01, 100, 100, 3, 1'b0, 1'b0, 1'b0,
                    10'h010, 32'h04030201, 10'h011, 32'h08070605};
        vecs[2] = '{10'h3FF, 10'd2, 8'h01, 100, 100, 0, 1'b0, 1'b0, 1'b1,
                    10'h3FF, 32'h04030201, 10'h000, 32'h08070605};
        vecs[3] = '{10'h100, 10'd1, 8'hA0, 100, 100, 0, 1'b0, 1'b1, 1'b1,
                    10'h100, 32'hA3A2A1A0, 10'h100, 32'hA3A2A1A0};
        vecs[4] = '{10'h040, 10'd3, 8'h20, 100, 100, 0, 1'b1, 1'b0, 1'b1,
                    10'h040, 32'h23222120, 10'h042, 32'h2B2A2928};
        vecs[5] = '{10'h200, 10'd3, 8'h10, 60, 50, 0, 1'b0, 1'b0, 1'b0,
                    10'h200, 32'h13121110, 10'h202, 32'h1B1A1918};

        i_rst = 1'b0; i_start = 1'b0; i_base_addr = '0; i_word_cnt = '0;
        i_packet = '0; i_valid = 1'b0; i_glb_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check({o_busy, o_done, o_ready, o_glb_we, o_glb_addr, o_glb_wdata} == '0,
              "reset_state", {o_busy, o_done, o_ready, o_glb_we, o_glb_addr, o_glb_wdata}, 64'h0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // Zero word count: done next cycle, no writes, never busy
        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = 10'h123; i_word_cnt = 10'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        #1;
        check(o_done && !o_busy && !o_glb_we && !o_ready, "zero_cnt_done",
              {o_done, o_busy, o_glb_we, o_ready}, 64'h8);
        @(negedge i_clk);
        #1;
        check(!o_done && !o_busy && !o_glb_we, "zero_cnt_after",
              {o_done, o_busy, o_glb_we}, 64'h0);

        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < 64; j++) pkt_src[j] = vecs[v].pkt0 + 8'(j);
            if (vecs[v].pre_reset) begin
                // Abort a transfer after two packets of its first word
                @(negedge i_clk);
                i_start = 1'b1; i_base_addr = 10'h050; i_word_cnt = 10'd2;
                @(negedge i_clk);
                i_start = 1'b0; i_valid = 1'b1; i_packet = 8'h55; i_glb_ready = 1'b1;
                @(negedge i_clk);
                i_packet = 8'h66;
                @(negedge i_clk);
                i_valid = 1'b0; i_rst = 1'b0;
                #1;
                check({o_busy, o_done, o_ready, o_glb_we, o_glb_addr, o_glb_wdata} == '0,
                      "reset_mid_xfer",
                      {o_busy, o_done, o_ready, o_glb_we, o_glb_addr, o_glb_wdata}, 64'h0);
                @(negedge i_clk);
                i_rst = 1'b1;
            end
            run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].vprob, vecs[v].rprob,
                     vecs[v].stall_n, vecs[v].mid_start,
                     n_wr, done_it, a_first, d_first, a_last, d_last);
            check(n_wr == int'(vecs[v].cnt), "vec_write_count", 64'(n_wr), 64'(vecs[v].cnt));
            check(a_first == vecs[v].exp_a_first && d_first == vecs[v].exp_d_first,
                  "vec_first_write", {a_first, d_first}, {vecs[v].exp_a_first, vecs[v].exp_d_first});
            check(a_last == vecs[v].exp_a_last && d_last == vecs[v].exp_d_last,
                  "vec_last_write", {a_last, d_last}, {vecs[v].exp_a_last, vecs[v].exp_d_last});
            if (vecs[v].full_rate)
                check(done_it == int'(vecs[v].cnt) * PN + 1, "vec_throughput",
                      64'(done_it), 64'(int'(vecs[v].cnt) * PN + 1));
        end

        // Randomized transfers against the reference queue
        for (int r = 0; r < 10; r++) begin
            rb = 10'($urandom);
            rc = 10'($urandom_range(1, 6));
            for (int j = 0; j < 64; j++) pkt_src[j] = 8'($urandom);
            run_xfer(rb, rc, $urandom_range(30, 100), $urandom_range(30, 100), 0, 1'b0,
                     n_wr, done_it, a_first, d_first, a_last, d_last);
            check(n_wr == int'(rc), "rand_write_count", 64'(n_wr), 64'(rc));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gon_glb_writer.md
# gon_glb_writer

Downstream consumer of the global output network bus: it accepts the serialized partial-sum/output packet stream that the GON bus delivers from the PE array, packs `PACK_NUM` consecutive packets into one GLB word, and writes those words to consecutive GLB addresses starting at a programmed base. It is configured and started by the top controller for each output transfer and signals completion with a one-cycle done pulse.

## Interface
- `DATA_BITWIDTH`, 8: width of one GON packet; matches the GON bus output packet width.
- `PACK_NUM`, 4: packets per GLB word; power of two, ≥2.
- `ADDR_BITWIDTH`, 10: GLB address width.
- `LEN_BITWIDTH`, 10: width of the word-count field.
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  one-cycle start strobe from top controller; honoured only in IDLE.
- `i_base_addr`  in  ADDR_BITWIDTH  first GLB word address; sampled on accepted start.
- `i_word_cnt`  in  LEN_BITWIDTH  number of GLB words to write; sampled on accepted start.
- `o_busy`  out  1  high from cycle after accepted start until final write handshake.
- `o_done`  out  1  registered one-cycle completion pulse.
- `i_packet`  in  DATA_BITWIDTH  packet from GON bus.
- `i_valid`  in  1  GON bus packet valid.
- `o_ready`  out  1  ready toward GON bus.
- `o_glb_we`  out  1  GLB write request (acts as valid).
- `o_glb_addr`  out  ADDR_BITWIDTH  GLB write address.
- `o_glb_wdata`  out  PACK_NUM*DATA_BITWIDTH  packed word; first packet in LSB lane.
- `i_glb_ready`  in  1  GLB accepts the write this cycle.

## Operation
- States: IDLE, RUN.
- IDLE: `o_ready`=0, `o_glb_we`=0. On `i_start`: latch base into address counter, latch count into remaining-word counter, clear lane index and packed-word counter; if `i_word_cnt`≠0 go to RUN, else stay IDLE and pulse `o_done` next cycle with no writes.
- RUN, input side: `o_ready` = (packed_words < word_cnt) && (!o_glb_we || i_glb_ready). Packet transfer = `i_valid && o_ready`; packet stored in lane `lane_idx`, lane_idx increments modulo PACK_NUM.
- On transfer into lane PACK_NUM-1: the full word (all lanes including the current packet) loads the output register, `o_glb_we` sets, packed_words increments.
- Output side: write handshake = `o_glb_we && i_glb_ready`. On handshake: `o_glb_addr` increments by 1 (wraps modulo 2^ADDR_BITWIDTH), remaining count decrements; `o_glb_we` clears unless a new word loads the same cycle (new word wins, register reloaded).
- `o_glb_addr`/`o_glb_wdata` held stable while `o_glb_we`=1 and `i_glb_ready`=0.
- Final handshake (remaining count 1→0): state→IDLE, `o_busy`→0 and `o_done`=1 in the following cycle.
- Packets beyond `word_cnt*PACK_NUM` are never accepted (`o_ready` low).
- `i_start` in RUN is ignored. `i_start` in the `o_done` cycle is accepted (state already IDLE).
- Reset (any time, including mid-transfer): state IDLE, all counters 0, lane registers 0, partial word discarded.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_ready`=0, `o_glb_we`=0, `o_glb_addr`=0, `o_glb_wdata`=0.
- Start accepted at cycle t → RUN and `o_ready` may be 1 at t+1.
- Packet completing a word transferred at t → `o_glb_we`=1 with that word at t+1.
- Sustained throughput with `i_valid`=`i_glb_ready`=1: one packet/cycle, one write per PACK_NUM cycles, no bubbles.
- `i_glb_ready` low while a write is pending blocks further input (`o_ready`=0) combinationally that cycle.
- Last handshake at t → `o_done`=1 at t+1 only; `o_busy`=0 from t+1.

## Test plan
- Base 0x010, count 2, PACK_NUM 4, packets 0x01..0x08 streamed back-to-back, `i_glb_ready`=1 -> writes 0x04030201@0x010, 0x08070605@0x011; `o_done` one cycle after second write; 9th packet not accepted.
- Same stream with `i_glb_ready` held low 3 cycles on first write -> `o_glb_we`/addr/data stable, `o_ready`=0 during stall, final data identical.
- Start with `i_word_cnt`=0 -> `o_done` pulse next cycle, no `o_glb_we`, `o_busy` stays 0.
- Base 0x3FF, count 2 -> writes at 0x3FF then 0x000.
- Reset asserted after 2 packets of a word -> all outputs 0; new start, 4 packets 0xA0..0xA3 -> single write 0xA3A2A1A0, no residue of old packets.
- `i_start` pulsed mid-RUN with different base -> ignored; transfer completes at original addresses.
